// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over XLEN cycles, with single-cycle handling of divide-by-zero and overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic                op_div;     // 1: DIV/DIVU/REM/REMU, 0: MUL family
  logic                op_alt;     // high half for multiply, remainder for divide
  logic                neg_res;
  logic                neg_rem;
  logic [XLEN-1:0]     operand;    // multiplicand, or divisor
  logic [2*XLEN-1:0]   acc;        // {hi, lo} product, or {remainder, quotient}

  // Decode of the incoming instruction, used only while accepting in IDLE.
  logic            in_div, in_alt, sign_a, sign_b, neg_a, neg_b;
  logic            div_by_zero, overflow;
  logic [XLEN-1:0] mag_a, mag_b;

  assign in_div      = funct3[2];
  assign in_alt      = in_div ? funct3[1] : (funct3[1:0] != 2'b00);
  assign sign_a      = in_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign sign_b      = in_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign neg_a       = sign_a & rs1_data[XLEN-1];
  assign neg_b       = sign_b & rs2_data[XLEN-1];
  assign mag_a       = neg_a ? -rs1_data : rs1_data;
  assign mag_b       = neg_b ? -rs2_data : rs2_data;
  assign div_by_zero = in_div && (rs2_data == '0);
  assign overflow    = in_div && !funct3[0] &&
                       (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

  // One iteration step for each operation, plus sign-corrected final result.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, operand};
    acc_next  = '0;
    if (op_div) begin
      if (div_diff[XLEN])
        acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
    prod_fix  = neg_res ? -acc_next : acc_next;
    quo_fix   = neg_res ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_fix   = neg_rem ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    final_res = '0;
    if (op_div)
      final_res = op_alt ? rem_fix : quo_fix;
    else
      final_res = op_alt ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  assign busy  = (state != IDLE);
  assign stall = ((state == IDLE) && start && !flush) || (state == CALC);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the reset branch clears every register, including the accumulator,
    // so a reset mid-operation leaves nothing behind.
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      op_div  <= 1'b0;
      op_alt  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      operand <= '0;
      acc     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              op_div  <= in_div;
              op_alt  <= in_alt;
              neg_res <= neg_a ^ neg_b;
              neg_rem <= neg_a;
              count   <= CW'(XLEN-1);
              if (div_by_zero) begin
                result <= in_alt ? rs1_data : '1;
                done   <= 1'b1;
                state  <= DONE;
              end else if (overflow) begin
                result <= in_alt ? '0 : rs1_data;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                operand <= in_div ? mag_b : mag_a;
                acc     <= in_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                state   <= CALC;
              end
            end
          end
          CALC: begin
            acc   <= acc_next;
            count <= count - 1'b1;
            if (count == '0) begin
              result <= final_res;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit with its own sequencing FSM, placed beside the ALU in the EX stage.
- Accepts one M-extension operation at a time (opcode ARITHMETIC, funct7 0000001) and stalls the pipeline while it iterates.
- Returns a result on a one-cycle done pulse.
- Opcode/funct7 decode is done upstream; this block receives funct3 only.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  EX holds an M-extension instruction; held high until done
- flush  input  1  squash in-flight operation (branch mispredict/exception)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  XLEN  operand A (dividend/multiplicand)
- rs2_data  input  XLEN  operand B (divisor/multiplier)
- stall  output  1  freeze PC/IF/ID/EX
- busy  output  1  FSM not IDLE
- done  output  1  result valid this cycle only
- result  output  XLEN  operation result

Behaviour:
- Reset (async, reset_n=0): state=IDLE; done=0, busy=0, result=0, counter=0, all accumulators 0. Reset mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch funct3 and operand magnitudes; record the result sign.
  - Signed operands are DIV/REM rs1/rs2, MULH rs1/rs2, MULHSU rs1 only.
  - Go to CALC with counter=XLEN-1.
  - Special cases go straight to DONE with the result preloaded:
    - divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
    - signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- CALC:
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract; quotient and remainder each XLEN bits.
  - counter decrements each cycle; at counter=0, apply sign correction, select result, go to DONE.
  - Result selection: MUL → low half; MULH* → high half; DIV* → quotient; REM* → remainder.
  - Sign rules: quotient is negated if operand signs differ; remainder takes the dividend's sign.
- DONE: done=1 and result valid for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE, so the completing instruction is never re-accepted.
- Latency:
  - Normal operation: start accepted at edge T; done high in cycle T+XLEN+1 (33 cycles for XLEN=32).
  - Special cases: done in cycle T+1.
- stall = (state==IDLE and start and not flush) or state==CALC. stall is 0 in DONE so the pipeline advances and captures result.
- busy = state!=IDLE.
- result holds its last value after DONE until the next completion. Consumers qualify it with done.
- flush=1 in any state forces IDLE on the next edge; done is not asserted. flush has priority over start and over the CALC→DONE transition.
- start is sampled only in IDLE; operand or funct3 changes during CALC have no effect.
- Back-to-back operations: the next start is accepted in the IDLE cycle following DONE. Minimum spacing between done pulses is XLEN+2 cycles.

Test Plan:
- Reset: reset_n=0 mid-CALC (cycle 10) → busy=0, done=0, result=0 immediately; no done after release.
- MUL 7 × -3 (rs1=7, rs2=0xFFFFFFFD), then MULH same operands → result 0xFFFFFFEB, then 0xFFFFFFFF. Each done appears exactly 33 cycles after start acceptance; stall high for cycles 0..32 and low in the done cycle.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/16 → 0x0FFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Divide by zero and overflow:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000/-1 → 0.
  - All with done one cycle after acceptance.
- Flush: flush=1 at CALC cycle 15 → IDLE next cycle, done never asserted, stall drops; a new start is accepted the following cycle and completes correctly.
- Back-to-back: start held through DONE, then new operands → exactly one done per operation, second done 34 cycles after the first.
